// File: rtl/pwm_multi_if.sv
// Control and output bundle of the multi-channel PWM generator.
// The control loop holds the master side; the generator takes the slave side.
interface pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int N        = 10,
  parameter int PW       = 8
);
  logic [PW-1:0]             prescale;
  logic                      center;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*(N+1)-1:0] duty;
  logic [CHANNELS-1:0]       signal;
  logic                      period_start;
  logic [N-1:0]              count;

  modport master (
    output prescale, center, en, duty,
    input  signal, period_start, count
  );

  modport slave (
    input  prescale, center, en, duty,
    output signal, period_start, count
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter with a clock-enable prescaler,
// edge- or center-aligned, with duty/enable/mode shadowed at period boundaries.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int N        = 10,
  parameter int PW       = 8
) (
  input  logic     clk,
  input  logic     reset,
  pwm_multi_if.slave bus
);
  localparam logic [N-1:0]  MAX  = '1;
  localparam logic [N-1:0]  ONE  = N'(1);
  localparam logic [N:0]    FULL = {1'b1, {N{1'b0}}};
  localparam logic [PW-1:0] PONE = PW'(1);

  typedef enum logic {UP, DOWN} dir_t;

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [N-1:0]        count, count_next;
  dir_t                dir, dir_next;
  logic                boundary;
  logic                center_sh;
  logic [CHANNELS-1:0] en_sh;
  logic [N:0]          duty_sh  [CHANNELS];
  logic [N:0]          duty_sat [CHANNELS];
  logic [CHANNELS-1:0] signal;
  logic                period_start;

  // >= rather than == so a prescale lowered below pre_cnt ticks at once.
  assign tick = (pre_cnt >= bus.prescale);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_next = count;
    dir_next   = dir;
    boundary   = 1'b0;
    if (tick) begin
      if (center_sh) begin
        if (dir == DOWN) begin
          if (count == ONE) boundary = 1'b1;
          else              count_next = count - ONE;
        end else begin
          count_next = count + ONE;
          if (count_next == MAX) dir_next = DOWN;
        end
      end else begin
        if (count == MAX) boundary = 1'b1;
        else              count_next = count + ONE;
      end
      if (boundary) begin
        count_next = '0;
        dir_next   = UP;
      end
    end
  end

  // Out-of-range duty requests clamp to 2^N, i.e. 100% on.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      duty_sat[c] = bus.duty[c*(N+1) +: N+1];
      if (duty_sat[c] > FULL) duty_sat[c] = FULL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt      <= '0;
      count        <= '0;
      dir          <= UP;
      center_sh    <= 1'b0;
      en_sh        <= '0;
      // NOTE: the duty shadow is reset too: outputs must stay low until the first boundary.
      for (int c = 0; c < CHANNELS; c++) duty_sh[c] <= '0;
      signal       <= '0;
      period_start <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      pre_cnt      <= tick ? '0 : pre_cnt + PONE;
      count        <= count_next;
      dir          <= dir_next;
      period_start <= boundary;
      if (boundary) begin
        center_sh <= bus.center;
        en_sh     <= bus.en;
        duty_sh   <= duty_sat;
      end
      for (int c = 0; c < CHANNELS; c++)
        signal[c] <= en_sh[c] & ({1'b0, count} < duty_sh[c]);
    end
  end

  assign bus.signal       = signal;
  assign bus.period_start = period_start;
  assign bus.count        = count;
endmodule
